// File: rtl/ssd_scan_driver_if.sv
// Display-side bundle: binary value in, anode/cathode pins and conversion status out.
interface ssd_scan_driver_if #(
  parameter int IN_W = 13
);
  logic [IN_W-1:0] num;
  logic [3:0]      anode;
  logic [6:0]      seg;
  logic            busy;

  modport master (output num, input anode, seg, busy);
  modport slave  (input num, output anode, seg, busy);
endinterface

// File: rtl/ssd_scan_driver.sv
// Binary-to-BCD via sequential double-dabble, then time-multiplexed onto a
// 4-digit common-anode seven-segment display with leading-zero blanking.

module ssd_digit (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (nib)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module ssd_scan_driver #(
  parameter int IN_W        = 13,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  ssd_scan_driver_if.slave  bus
);
  localparam int NUM_DIG = 4;
  localparam int CNT_W   = $clog2(IN_W + 1);
  localparam int REF_W   = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t state, state_nxt;

  logic [IN_W-1:0]              bin, shown;
  logic [NUM_DIG-1:0][3:0]      bcd, bcd_adj, disp_bcd;
  logic [4*NUM_DIG-1:0]         adj_flat;
  logic [CNT_W-1:0]             shift_cnt;
  logic                         start, last_shift;

  logic [REF_W-1:0]             ref_cnt;
  logic [1:0]                   idx;
  logic [NUM_DIG-1:0]           blank;
  logic [NUM_DIG-1:0][6:0]      digit_seg;

  assign start      = (state == IDLE) && (bus.num != shown);
  assign last_shift = (shift_cnt == CNT_W'(IN_W - 1));
  assign bus.busy   = (state != IDLE);
  assign adj_flat   = bcd_adj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-digit add-3 correction and display decode with leading-zero blanking.
  for (genvar d = 0; d < NUM_DIG; d++) begin : g_dig
    assign bcd_adj[d] = (bcd[d] >= 4'd5) ? bcd[d] + 4'd3 : bcd[d];

    if (d == 0) begin : g_ones
      assign blank[d] = 1'b0;
    end else if (d == NUM_DIG - 1) begin : g_top
      assign blank[d] = (disp_bcd[d] == 4'd0);
    end else begin : g_mid
      assign blank[d] = (disp_bcd[d] == 4'd0) && blank[d+1];
    end

    ssd_digit u_dig (
      .nib   (disp_bcd[d]),
      .blank (blank[d]),
      .seg   (digit_seg[d])
    );
  end

  // disp_bcd is only written in LOAD so the scan never sees a half-built value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin       <= '0;
      shown     <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      disp_bcd  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin       <= bus.num;
          shown     <= bus.num;
          bcd       <= '0;
          shift_cnt <= '0;
        end
        SHIFT: begin
          bcd       <= {adj_flat[4*NUM_DIG-2:0], bin[IN_W-1]};
          bin       <= bin << 1;
          shift_cnt <= shift_cnt + 1'b1;
        end
        LOAD:    disp_bcd <= bcd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.anode <= 4'b1110;
      bus.seg   <= 7'b1000000;
    end else begin
      bus.anode <= ~(4'b0001 << idx);
      bus.seg   <= digit_seg[idx];
    end
  end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: value-level reference model checked every
// cycle, plus literal scan/busy expectations for each scenario.
module tb_ssd_scan_driver;
  localparam int IN_W = 13;
  localparam int DIV  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   armed = 1'b0;

  ssd_scan_driver_if #(.IN_W(IN_W)) bus();

  ssd_scan_driver #(.IN_W(IN_W), .REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Segment pattern of decimal digit k of val, with leading-zero blanking.
  function automatic logic [6:0] seg_of(input int val, input int k);
    int p = 1;
    int d;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && val < p) return 7'b1111111;
    d = (val / p) % 10;
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Reference: a sampled value becomes visible IN_W+1 cycles later; the scan
  // position follows a free-running cycle count.
  int         m_shown, m_pend, m_left, m_disp, m_ref, m_idx;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_shown <= 0; m_pend <= 0; m_left <= 0; m_disp <= 0;
      m_ref <= 0; m_idx <= 0; m_an <= 4'b1110; m_seg <= 7'b1000000;
    end else begin
      m_an  <= ~(4'b0001 << m_idx);
      m_seg <= seg_of(m_disp, m_idx);
      if (m_left == 0) begin
        if (int'(bus.num) != m_shown) begin
          m_shown <= int'(bus.num);
          m_pend  <= int'(bus.num);
          m_left  <= IN_W + 1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) m_disp <= m_pend;
      end
      if (m_ref == DIV - 1) begin
        m_ref <= 0;
        m_idx <= (m_idx + 1) % 4;
      end else begin
        m_ref <= m_ref + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_anode", int'(bus.anode), int'(m_an));
      chk("model_seg",   int'(bus.seg),   int'(m_seg));
      chk("model_busy",  int'(bus.busy),  int'(m_left != 0));
    end
  end

  task automatic set_num(input int v);
    @(negedge clk);
    bus.num = IN_W'(v);
  endtask

  task automatic wait_rise(input string nm);
    int t = 0;
    while (!bus.busy && t < 6) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_busy_rise"}, int'(bus.busy), 1);
  endtask

  task automatic count_busy(input string nm, input int exp);
    int len = 0;
    while (bus.busy && len < 40) begin
      len++;
      @(negedge clk);
    end
    chk({nm, "_busy_len"}, len, exp);
  endtask

  // Collect one full scan; a digit whose pattern flickers is recorded as 'hEE.
  task automatic check_scan(input string nm, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [7:0] got [4];
    logic [6:0] e [4];
    int k;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++) got[i] = 8'hFF;
    repeat (4 * DIV + 2) begin
      @(negedge clk);
      k = -1;
      case (bus.anode)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      if (k >= 0) begin
        if (got[k] == 8'hFF) got[k] = {1'b0, bus.seg};
        else if (got[k] != {1'b0, bus.seg}) got[k] = 8'hEE;
      end
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_dig%0d", nm, i), int'(got[i]), int'({1'b0, e[i]}));
  endtask

  localparam logic [6:0] BL = 7'b1111111;

  initial begin
    bus.num = '0;
    #3 rst = 1'b0;
    armed = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_anode", int'(bus.anode), 4'b1110);
    chk("rst_seg",   int'(bus.seg),   7'b1000000);
    chk("rst_busy",  int'(bus.busy),  0);
    rst = 1'b1;

    // 1: zero stays idle, only the ones digit lit
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("zero_idle", int'(bus.busy), 0);
    end
    check_scan("zero", 7'b1000000, BL, BL, BL);

    // 2: 1234
    set_num(1234);
    wait_rise("n1234");
    count_busy("n1234", 14);
    check_scan("n1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    // 3: maximum value
    set_num(8191);
    wait_rise("n8191");
    count_busy("n8191", 14);
    check_scan("n8191", 7'b1111001, 7'b0010000, 7'b1111001, 7'b0000000);

    // 4: single digit, upper digits blank
    set_num(7);
    wait_rise("n7");
    count_busy("n7", 14);
    check_scan("n7", 7'b1111000, BL, BL, BL);

    // interior zeros are not blanked
    set_num(1000);
    wait_rise("n1000");
    count_busy("n1000", 14);
    check_scan("n1000", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001);

    // 5: change while busy, last value wins after one idle cycle
    set_num(1234);
    wait_rise("chg");
    repeat (4) @(negedge clk);
    bus.num = IN_W'(56);
    count_busy("chg_first", 10);
    @(negedge clk);
    chk("chg_rearm", int'(bus.busy), 1);
    count_busy("chg_second", 14);
    check_scan("n56", 7'b0000010, 7'b0010010, BL, BL);

    // 6: reset in mid-conversion
    set_num(999);
    wait_rise("abort");
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_anode", int'(bus.anode), 4'b1110);
    chk("abort_seg",   int'(bus.seg),   7'b1000000);
    chk("abort_busy",  int'(bus.busy),  0);
    @(negedge clk);
    rst = 1'b1;
    wait_rise("n999");
    count_busy("n999", 14);
    check_scan("n999", 7'b0010000, 7'b0010000, 7'b0010000, BL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
